// File: rtl/mem_except_pkg.sv
// mem_except_pkg: shared definitions for the MEM-stage exception resolution
// slice. Holds resolved exception codes, excepttype_i flag positions, CP0
// register addresses, Status bit indices and the FSM state encoding.
package mem_except_pkg;

   // Resolved exception codes driven on excepttype_o
   localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
   localparam logic [31:0] EXC_INT     = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
   localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
   localparam logic [31:0] EXC_OV      = 32'h0000_000c;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

   // Flag positions inside excepttype_i
   localparam int EXC_BIT_SYSCALL = 8;
   localparam int EXC_BIT_INVALID = 9;
   localparam int EXC_BIT_TRAP    = 10;
   localparam int EXC_BIT_OV      = 11;
   localparam int EXC_BIT_ERET    = 12;
   localparam int EXC_BIT_LO      = EXC_BIT_SYSCALL;
   localparam int EXC_BIT_HI      = EXC_BIT_ERET;

   // CP0 register addresses
   localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
   localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

   // Status register bit indices
   localparam int STATUS_IE  = 0;
   localparam int STATUS_EXL = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

endpackage

// File: rtl/mem_except_if.sv
// mem_except_if: bundles the MEM-stage flags, CP0 register values, the WB-stage
// CP0 write port and the resolved exception / flush outputs of mem_except.
//   slave  : used by mem_except (inputs are MEM/CP0/WB, outputs are results)
//   master : used by the surrounding pipeline / testbench
interface mem_except_if;
   logic        mem_valid_i;
   logic [31:0] excepttype_i;
   logic [31:0] current_inst_addr_i;
   logic        is_in_delayslot_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic [31:0] excepttype_o;
   logic        exc_we_o;
   logic [31:0] exc_epc_o;
   logic        exc_bd_o;
   logic [31:0] cp0_epc_o;
   logic        flush_o;
   logic [31:0] new_pc_o;

   modport slave (
      input  mem_valid_i, excepttype_i, current_inst_addr_i, is_in_delayslot_i,
      input  cp0_status_i, cp0_cause_i, cp0_epc_i,
      input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      output excepttype_o, exc_we_o, exc_epc_o, exc_bd_o, cp0_epc_o,
      output flush_o, new_pc_o
   );

   modport master (
      output mem_valid_i, excepttype_i, current_inst_addr_i, is_in_delayslot_i,
      output cp0_status_i, cp0_cause_i, cp0_epc_i,
      output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      input  excepttype_o, exc_we_o, exc_epc_o, exc_bd_o, cp0_epc_o,
      input  flush_o, new_pc_o
   );
endinterface

// File: rtl/mem_except_prio.sv
// except_prio: combinational fixed-priority encoder.
//   int_pending_i : interrupt condition already qualified by IE/EXL
//   flags_i       : excepttype_i[12:8] (syscall, invalid, trap, ov, eret)
//   code_o        : resolved exception code, EXC_NONE when nothing is flagged
// Priority: interrupt > syscall > invalid > trap > overflow > eret.
module except_prio
   import mem_except_pkg::*;
(
   input  logic        int_pending_i,
   input  logic [4:0]  flags_i,
   output logic [31:0] code_o
);

   always_comb begin
      code_o = EXC_NONE;
      if (int_pending_i)
         code_o = EXC_INT;
      else if (flags_i[EXC_BIT_SYSCALL - EXC_BIT_LO])
         code_o = EXC_SYSCALL;
      else if (flags_i[EXC_BIT_INVALID - EXC_BIT_LO])
         code_o = EXC_INVALID;
      else if (flags_i[EXC_BIT_TRAP - EXC_BIT_LO])
         code_o = EXC_TRAP;
      else if (flags_i[EXC_BIT_OV - EXC_BIT_LO])
         code_o = EXC_OV;
      else if (flags_i[EXC_BIT_ERET - EXC_BIT_LO])
         code_o = EXC_ERET;
   end

endmodule

// File: rtl/mem_except.sv
// mem_except: exception resolution between MEM and CP0.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_except_if.slave carrying MEM flags, CP0 values, the WB
//              CP0 write port, the same-cycle commit (excepttype_o, exc_we_o,
//              exc_epc_o, exc_bd_o, cp0_epc_o) and the registered flush /
//              redirect (flush_o, new_pc_o).
// Parameters: EXC_VECTOR handler address, FLUSH_CYCLES flush length (1..15).
// Optional build macro MEM_EXCEPT_BD_EN: delay-slot exceptions report
// EPC = PC-4 and BD = 1; without it EPC = PC and BD = 0.
module mem_except
   import mem_except_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int          FLUSH_CYCLES = 1
)(
   input  logic        clk,
   input  logic        rst,
   mem_except_if.slave bus
);

   localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

   logic [31:0] eff_status, eff_cause, eff_epc;
   logic        int_pending;
   logic [31:0] raw_code, code;
   logic        detect_en;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;

   logic        exc_we;
   logic [31:0] exc_epc;
   logic        exc_bd;

   // A CP0 write retiring in WB this cycle must be visible to the instruction
   // in MEM. Only the software-writable Cause bits (IP1:0, IV, WP) forward.
   always_comb begin
      eff_status = bus.cp0_status_i;
      eff_cause  = bus.cp0_cause_i;
      eff_epc    = bus.cp0_epc_i;
      if (bus.wb_cp0_we_i) begin
         case (bus.wb_cp0_waddr_i)
            CP0_ADDR_STATUS: eff_status = bus.wb_cp0_data_i;
            CP0_ADDR_CAUSE: begin
               eff_cause[9:8]   = bus.wb_cp0_data_i[9:8];
               eff_cause[23:22] = bus.wb_cp0_data_i[23:22];
            end
            CP0_ADDR_EPC:    eff_epc = bus.wb_cp0_data_i;
            default: ;
         endcase
      end
   end

   assign int_pending = (|(eff_cause[15:8] & eff_status[15:8]))
                        && eff_status[STATUS_IE] && !eff_status[STATUS_EXL];

   except_prio u_prio (
      .int_pending_i (int_pending),
      .flags_i       (bus.excepttype_i[EXC_BIT_HI:EXC_BIT_LO]),
      .code_o        (raw_code)
   );

   // Instructions in MEM during FLUSH are being squashed, so they never raise.
   assign detect_en = bus.mem_valid_i && (state_q == ST_IDLE) && !rst;
   assign code      = detect_en ? raw_code : EXC_NONE;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         flush_q  <= 1'b0;
         new_pc_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flush_q  <= flush_d;
         new_pc_q <= new_pc_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      flush_d  = flush_q;
      new_pc_d = new_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (code != EXC_NONE) begin
               state_d  = ST_FLUSH;
               flush_d  = 1'b1;
               cnt_d    = CNT_INIT;
               new_pc_d = (code == EXC_ERET) ? eff_epc : EXC_VECTOR;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
               flush_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: same-cycle commit to CP0. ERET commits nothing.
   always_comb begin
      exc_we  = (code != EXC_NONE) && (code != EXC_ERET);
      exc_epc = rst ? 32'd0 : bus.current_inst_addr_i;
      exc_bd  = 1'b0;
`ifdef MEM_EXCEPT_BD_EN
      if (exc_we && bus.is_in_delayslot_i) begin
         exc_epc = bus.current_inst_addr_i - 32'd4;
         exc_bd  = 1'b1;
      end
`endif
   end

   assign bus.excepttype_o = code;
   assign bus.exc_we_o     = exc_we;
   assign bus.exc_epc_o    = exc_epc;
   assign bus.exc_bd_o     = exc_bd;
   assign bus.cp0_epc_o    = rst ? 32'd0 : eff_epc;
   assign bus.flush_o      = flush_q;
   assign bus.new_pc_o     = new_pc_q;

   // Register bits that play no part in exception resolution
   logic unused_bits;
`ifdef MEM_EXCEPT_BD_EN
   assign unused_bits = ^{bus.excepttype_i[31:13], bus.excepttype_i[7:0],
                          eff_status[31:16], eff_status[7:2],
                          eff_cause[31:16], eff_cause[7:0]};
`else
   assign unused_bits = ^{bus.excepttype_i[31:13], bus.excepttype_i[7:0],
                          eff_status[31:16], eff_status[7:2],
                          eff_cause[31:16], eff_cause[7:0],
                          bus.is_in_delayslot_i};
`endif

endmodule

// File: tb/tb_mem_except.sv
// tb_mem_except: directed bench for mem_except. dut_a uses FLUSH_CYCLES=1,
// dut_b uses FLUSH_CYCLES=3; both see identical stimulus.
module tb_mem_except;
   import mem_except_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   mem_except_if ifa ();
   mem_except_if ifb ();

   mem_except #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   mem_except #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] et, input logic [31:0] addr,
                        input logic ds, input logic [31:0] st, input logic [31:0] ca,
                        input logic [31:0] ep, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
      ifa.mem_valid_i = v;   ifb.mem_valid_i = v;
      ifa.excepttype_i = et; ifb.excepttype_i = et;
      ifa.current_inst_addr_i = addr; ifb.current_inst_addr_i = addr;
      ifa.is_in_delayslot_i = ds; ifb.is_in_delayslot_i = ds;
      ifa.cp0_status_i = st; ifb.cp0_status_i = st;
      ifa.cp0_cause_i = ca;  ifb.cp0_cause_i = ca;
      ifa.cp0_epc_i = ep;    ifb.cp0_epc_i = ep;
      ifa.wb_cp0_we_i = we;  ifb.wb_cp0_we_i = we;
      ifa.wb_cp0_waddr_i = wa; ifb.wb_cp0_waddr_i = wa;
      ifa.wb_cp0_data_i = wd;  ifb.wb_cp0_data_i = wd;
   endtask

   // Inputs change 1 time unit after the rising edge, checks 1 unit later.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input int n);
      drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < n; i++) next();
   endtask

   initial begin
      // Reset with a syscall flagged and EPC nonzero: everything must read 0
      drive(1'b1, 32'h100, 32'h100, 1'b0, 32'd0, 32'd0, 32'h123, 1'b0, 5'd0, 32'd0);
      next(); next(); #1;
      chk("rst_code", ifa.excepttype_o, 32'h0);
      chk("rst_we", {31'd0, ifa.exc_we_o}, 32'd0);
      chk("rst_epc", ifa.exc_epc_o, 32'h0);
      chk("rst_bd", {31'd0, ifa.exc_bd_o}, 32'd0);
      chk("rst_cp0epc", ifa.cp0_epc_o, 32'h0);
      chk("rst_flush", {31'd0, ifa.flush_o}, 32'd0);
      chk("rst_newpc", ifa.new_pc_o, 32'h0);

      // Syscall at 0x100
      next();
      rst = 1'b0;
      drive(1'b1, 32'h100, 32'h100, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      chk("sys_code", ifa.excepttype_o, 32'h8);
      chk("sys_we", {31'd0, ifa.exc_we_o}, 32'd1);
      chk("sys_epc", ifa.exc_epc_o, 32'h100);
      chk("sys_flush_pre", {31'd0, ifa.flush_o}, 32'd0);
      next();
      quiet(0);
      chk("sys_flush", {31'd0, ifa.flush_o}, 32'd1);
      chk("sys_newpc", ifa.new_pc_o, 32'h20);
      next();
      chk("sys_flush_end", {31'd0, ifa.flush_o}, 32'd0);
      chk("sys_newpc_hold", ifa.new_pc_o, 32'h20);
      quiet(4);

      // ERET with EPC forwarded from WB
      drive(1'b1, 32'h1000, 32'h300, 1'b0, 32'd0, 32'd0, 32'h400, 1'b1, 5'd14, 32'h500);
      #1;
      chk("eret_code", ifa.excepttype_o, 32'he);
      chk("eret_we", {31'd0, ifa.exc_we_o}, 32'd0);
      chk("eret_cp0epc", ifa.cp0_epc_o, 32'h500);
      next();
      quiet(0);
      chk("eret_flush", {31'd0, ifa.flush_o}, 32'd1);
      chk("eret_newpc", ifa.new_pc_o, 32'h500);
      quiet(4);

      // Interrupt beats syscall and overflow
      drive(1'b1, 32'h900, 32'h40, 1'b0, 32'h401, 32'h400, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      chk("int_code", ifa.excepttype_o, 32'h1);
      chk("int_we", {31'd0, ifa.exc_we_o}, 32'd1);
      quiet(4);

      // EXL set masks the interrupt
      drive(1'b1, 32'h900, 32'h40, 1'b0, 32'h403, 32'h400, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      chk("exl_code", ifa.excepttype_o, 32'h8);
      quiet(4);

      // Cause forwarding: bit10 is not a forwarded bit, bit8 is
      drive(1'b1, 32'h100, 32'h40, 1'b0, 32'h401, 32'h0, 32'd0, 1'b1, 5'd13, 32'h400);
      #1;
      chk("cause_fwd_nobit10", ifa.excepttype_o, 32'h8);
      quiet(4);
      drive(1'b1, 32'h100, 32'h40, 1'b0, 32'h101, 32'h0, 32'd0, 1'b1, 5'd13, 32'h100);
      #1;
      chk("cause_fwd_bit8", ifa.excepttype_o, 32'h1);
      quiet(4);

      // Status forwarding enables the interrupt
      drive(1'b1, 32'h0, 32'h40, 1'b0, 32'h0, 32'h400, 32'd0, 1'b1, 5'd12, 32'h401);
      #1;
      chk("status_fwd", ifa.excepttype_o, 32'h1);
      quiet(4);

      // Bubble with trap flagged
      drive(1'b0, 32'h400, 32'h40, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      chk("bubble_code", ifa.excepttype_o, 32'h0);
      chk("bubble_we", {31'd0, ifa.exc_we_o}, 32'd0);
      next();
      chk("bubble_flush", {31'd0, ifa.flush_o}, 32'd0);
      quiet(2);

      // Trap; dut_b flushes 3 cycles and ignores a trap in its 2nd flush cycle,
      // while dut_a is back in IDLE then and accepts it.
      drive(1'b1, 32'h400, 32'h80, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      chk("trap_code_b", ifb.excepttype_o, 32'hd);
      next();
      quiet(0);
      chk("b_flush_c1", {31'd0, ifb.flush_o}, 32'd1);
      next();
      drive(1'b1, 32'h400, 32'h84, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      chk("b_flush_c2", {31'd0, ifb.flush_o}, 32'd1);
      chk("b_trap_ignored", ifb.excepttype_o, 32'h0);
      chk("b_we_ignored", {31'd0, ifb.exc_we_o}, 32'd0);
      chk("a_backtoback", ifa.excepttype_o, 32'hd);
      next();
      quiet(0);
      chk("b_flush_c3", {31'd0, ifb.flush_o}, 32'd1);
      chk("a_b2b_flush", {31'd0, ifa.flush_o}, 32'd1);
      next();
      chk("b_flush_c4", {31'd0, ifb.flush_o}, 32'd0);
      next();
      chk("b_flush_c5", {31'd0, ifb.flush_o}, 32'd0);
      quiet(3);

      // Reset in the middle of dut_b's flush
      drive(1'b1, 32'h100, 32'h180, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      next();
      quiet(0);
      chk("mid_flush_b", {31'd0, ifb.flush_o}, 32'd1);
      rst = 1'b1;
      drive(1'b1, 32'h800, 32'h1c0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      chk("rst_gate_code", ifb.excepttype_o, 32'h0);
      next();
      rst = 1'b0;
      quiet(0);
      chk("rst_mid_flush", {31'd0, ifb.flush_o}, 32'd0);
      chk("rst_mid_newpc", ifb.new_pc_o, 32'h0);
      next();
      drive(1'b1, 32'h800, 32'h1c0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      chk("post_rst_ov", ifb.excepttype_o, 32'hc);
      next();
      quiet(0);
      chk("post_rst_flush", {31'd0, ifb.flush_o}, 32'd1);
      quiet(5);

      // Overflow in a delay slot
      drive(1'b1, 32'h800, 32'h204, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      chk("bd_code", ifa.excepttype_o, 32'hc);
`ifdef MEM_EXCEPT_BD_EN
      chk("bd_epc", ifa.exc_epc_o, 32'h200);
      chk("bd_flag", {31'd0, ifa.exc_bd_o}, 32'd1);
`else
      chk("bd_epc", ifa.exc_epc_o, 32'h204);
      chk("bd_flag", {31'd0, ifa.exc_bd_o}, 32'd0);
`endif
      quiet(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_except.md
Name: mem_except

Overview:
- Exception resolution stage between the MEM stage and the CP0 register block.
- Combines MEM-stage exception flags with CP0 Status/Cause/EPC, forwarding any same-cycle WB-stage CP0 write.
- Selects one exception by fixed priority and issues a same-cycle commit pulse so CP0 captures EPC/Cause/EXL.
- Sequences a registered pipeline flush and PC redirect through a small FSM.

Parameters:
- EXC_VECTOR, 32'h0000_0020, handler entry address for all non-ERET exceptions.
- FLUSH_CYCLES, 1, number of cycles flush_o is held (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid_i  in  1  MEM stage holds a real instruction, not a bubble
- excepttype_i  in  32  MEM flags: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret
- current_inst_addr_i  in  32  PC of the MEM-stage instruction
- is_in_delayslot_i  in  1  MEM-stage instruction is in a delay slot
- cp0_status_i / cp0_cause_i / cp0_epc_i  in  32 each  current CP0 register values
- wb_cp0_we_i  in  1  WB-stage CP0 write enable
- wb_cp0_waddr_i  in  5  WB-stage CP0 write address
- wb_cp0_data_i  in  32  WB-stage CP0 write data
- excepttype_o  out  32  resolved code: 0x1 int, 0x8 syscall, 0xa invalid, 0xd trap, 0xc ov, 0xe eret, 0 none
- exc_we_o  out  1  one-cycle commit pulse to CP0
- exc_epc_o  out  32  EPC value to capture
- exc_bd_o  out  1  Cause.BD value to capture
- cp0_epc_o  out  32  forwarded EPC
- flush_o  out  1  pipeline flush, registered
- new_pc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- Forwarding:
  - If wb_cp0_we_i=1 and the address is Status(12) or EPC(14), the effective register equals wb_cp0_data_i.
  - If the address is Cause(13), the effective Cause takes wb_cp0_data_i bits 9:8, 22 and 23; all other bits come from cp0_cause_i.
- Interrupt condition: (effCause[15:8] & effStatus[15:8]) != 0, effStatus[0]=1 (IE), and effStatus[1]=0 (EXL).
- Detection is combinational. It requires mem_valid_i=1 and state=IDLE; otherwise excepttype_o=0 and exc_we_o=0.
- Priority: interrupt > syscall > invalid > trap > overflow > eret.
- exc_we_o=1 in the detection cycle for any nonzero code except 0xe. ERET commits nothing; CP0 clears EXL on its own ERET path.
- exc_epc_o is current_inst_addr_i. exc_bd_o is 0 (see Optional Feature).
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH on the edge after a nonzero excepttype_o.
  - On that edge: flush_o<=1; new_pc_o<=effEPC if code=0xe, else EXC_VECTOR; counter<=FLUSH_CYCLES-1.
  - In FLUSH: counter decrements each cycle. When counter=0, next state is IDLE and flush_o<=0.
  - Flush latency is 1 cycle after detection. Duration is exactly FLUSH_CYCLES cycles.
  - No new detection occurs in FLUSH; flagged instructions there are being flushed.
- Back-to-back: an exception seen in the first IDLE cycle after FLUSH is accepted normally.
- Reset (any cycle, including mid-FLUSH) forces:
  - state=IDLE, counter=0
  - flush_o=0, new_pc_o=0
  - excepttype_o=0, exc_we_o=0, exc_epc_o=0, exc_bd_o=0, cp0_epc_o=0
- new_pc_o holds its last value after FLUSH ends.

Optional Feature:
- Macro: MEM_EXCEPT_BD_EN
- Defined: when is_in_delayslot_i=1 on a committed exception, exc_epc_o=current_inst_addr_i-4 (32-bit wrap) and exc_bd_o=1.
- Undefined: exc_epc_o=current_inst_addr_i and exc_bd_o=0 always; is_in_delayslot_i is ignored.

Decomposition:
- Shared defines package holds:
  - exception code constants 0x1/0x8/0xa/0xd/0xc/0xe
  - excepttype_i bit positions
  - CP0 register addresses 12/13/14
  - Status IE/EXL bit indices
  - FSM state encodings
- One natural sub-module: except_prio, a purely combinational priority encoder from the flags and interrupt condition to the code.

Test Plan:
- Syscall: excepttype_i[8]=1, addr 0x100, IDLE -> excepttype_o=0x8 and exc_we_o=1, exc_epc_o=0x100 that cycle; next cycle flush_o=1, new_pc_o=0x20 for 1 cycle.
- ERET: excepttype_i[12]=1, cp0_epc_i=0x400 and WB writing EPC=0x500 same cycle -> exc_we_o=0, cp0_epc_o=0x500 that cycle; next cycle new_pc_o=0x500.
- Interrupt priority:
  - Status=0x0000_0401, Cause[10]=1, syscall and overflow also flagged -> code 0x1.
  - Same with Status[1]=1 -> code 0x8.
- Bubble/FLUSH gating:
  - mem_valid_i=0 with trap flagged -> no response.
  - With FLUSH_CYCLES=3, a trap in FLUSH cycle 2 is ignored; flush_o is high exactly 3 cycles.
- Reset asserted mid-FLUSH: next cycle flush_o=0, new_pc_o=0, state IDLE; an overflow flagged one cycle after rst deasserts -> code 0xc.
- MEM_EXCEPT_BD_EN defined, overflow at 0x204 in delay slot -> exc_epc_o=0x200, exc_bd_o=1; undefined -> 0x204 and 0.
